// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: MemOp codes, FSM states, lane selects.
// Misalignment helper is used only when LSU_MISALIGN_TRAP_EN is defined.
package lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  localparam logic [1:0] LANE_B0 = 2'd0;
  localparam logic [1:0] LANE_B1 = 2'd1;
  localparam logic [1:0] LANE_B2 = 2'd2;
  localparam logic [1:0] LANE_B3 = 2'd3;
  localparam logic       HALF_LO = 1'b0;
  localparam logic       HALF_HI = 1'b1;

  function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] lo);
    case (op)
      OP_LW, OP_SW:          is_misaligned = (lo != 2'b00);
      OP_LH, OP_LHU, OP_SH:  is_misaligned = lo[0];
      default:               is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Word-only data memory bus between the load/store unit (master) and memory (slave).
interface load_store_unit_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] MemAddress;
  logic [31:0]       MemWriteData;
  logic              MemWrite;
  logic              MemRead;
  logic [31:0]       MemReadData;

  modport master (
    output MemAddress, MemWriteData, MemWrite, MemRead,
    input  MemReadData
  );

  modport slave (
    input  MemAddress, MemWriteData, MemWrite, MemRead,
    output MemReadData
  );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// Combinational lane select and sign/zero extension of a memory word for loads.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [2:0]  op,
  input  logic [1:0]  lane,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      LANE_B0: byte_sel = word[7:0];
      LANE_B1: byte_sel = word[15:8];
      LANE_B2: byte_sel = word[23:16];
      LANE_B3: byte_sel = word[31:24];
      default: byte_sel = word[7:0];
    endcase
    half_sel = (lane[1] == HALF_HI) ? word[31:16] : word[15:0];
  end

  always_comb begin
    data = word;
    case (op)
      OP_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  data = {24'd0, byte_sel};
      OP_LH:   data = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  data = {16'd0, half_sel};
      default: data = word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: load extension, SW pass-through, SB/SH as two-cycle read-modify-write.
// Optional macro LSU_MISALIGN_TRAP_EN: flag and suppress misaligned accesses.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [ADDR_W-1:0] Address,
  input  logic [DATA_W-1:0] StoreData,
  input  logic [2:0]        MemOp,
  input  logic              MemReq,
  output logic [DATA_W-1:0] LoadData,
  output logic              Stall,
  output logic              ExcMisalign,
  load_store_unit_if.master dmem
);

  logic [0:0]        state_q, state_d;
  logic [31:0]       merge_q, merge_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       ext_data;
  logic [31:0]       merged;
  logic              is_load;
  logic              misalign;

  load_extend u_load_extend (
    .word (dmem.MemReadData),
    .op   (MemOp),
    .lane (Address[1:0]),
    .data (ext_data)
  );

  always_comb begin
    merged = dmem.MemReadData;
    if (MemOp == OP_SB) begin
      case (Address[1:0])
        LANE_B0: merged[7:0]   = StoreData[7:0];
        LANE_B1: merged[15:8]  = StoreData[7:0];
        LANE_B2: merged[23:16] = StoreData[7:0];
        LANE_B3: merged[31:24] = StoreData[7:0];
        default: merged = dmem.MemReadData;
      endcase
    end else if (Address[1] == HALF_HI) begin
      merged[31:16] = StoreData[15:0];
    end else begin
      merged[15:0] = StoreData[15:0];
    end
  end

  always_comb begin
    is_load = (MemOp == OP_LW) || (MemOp == OP_LH) || (MemOp == OP_LHU) ||
              (MemOp == OP_LB) || (MemOp == OP_LBU);
`ifdef LSU_MISALIGN_TRAP_EN
    misalign = MemReq && (state_q == ST_IDLE) && is_misaligned(MemOp, Address[1:0]);
`else
    misalign = 1'b0;
`endif
  end

  always_comb begin
    state_d           = state_q;
    merge_d           = merge_q;
    addr_d            = addr_q;
    Stall             = 1'b0;
    LoadData          = '0;
    ExcMisalign       = misalign;
    dmem.MemRead      = 1'b0;
    dmem.MemWrite     = 1'b0;
    dmem.MemAddress   = {Address[ADDR_W-1:2], 2'b00};
    dmem.MemWriteData = StoreData;
    case (state_q)
      ST_IDLE: begin
        if (MemReq && !misalign) begin
          if (is_load) begin
            dmem.MemRead = 1'b1;
            LoadData     = ext_data;
          end else if (MemOp == OP_SW) begin
            dmem.MemWrite = 1'b1;
          end else begin
            // Read phase of sub-word store: hold datapath while the merged word is latched.
            dmem.MemRead = 1'b1;
            Stall        = 1'b1;
            merge_d      = merged;
            addr_d       = Address[ADDR_W-1:2];
            state_d      = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        dmem.MemWrite     = 1'b1;
        dmem.MemAddress   = {addr_q, 2'b00};
        dmem.MemWriteData = merge_q;
        state_d           = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      merge_q <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      merge_q <= merge_d;
      addr_q  <= addr_d;
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit with a small word-addressed memory model.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] address;
  logic [31:0] store_data;
  logic [2:0]  mem_op;
  logic        mem_req;
  logic [31:0] load_data;
  logic        stall;
  logic        exc;

  logic [31:0] mem_arr [8];
  logic        pre_we;
  logic [2:0]  pre_idx;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  load_store_unit_if #(.ADDR_W(32)) bus ();

  assign bus.MemReadData = mem_arr[bus.MemAddress[4:2]];

  always @(posedge clk) begin
    if (pre_we)
      mem_arr[pre_idx] <= pre_data;
    else if (bus.MemWrite)
      mem_arr[bus.MemAddress[4:2]] <= bus.MemWriteData;
  end

  load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .Clk         (clk),
    .Reset_n     (rst_n),
    .Address     (address),
    .StoreData   (store_data),
    .MemOp       (mem_op),
    .MemReq      (mem_req),
    .LoadData    (load_data),
    .Stall       (stall),
    .ExcMisalign (exc),
    .dmem        (bus)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] data);
    mem_op     = op;
    address    = addr;
    store_data = data;
    mem_req    = 1'b1;
  endtask

  task automatic preload(input logic [2:0] idx, input logic [31:0] data);
    mem_req  = 1'b0;
    pre_we   = 1'b1;
    pre_idx  = idx;
    pre_data = data;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    pre_we     = 1'b0;
    pre_idx    = '0;
    pre_data   = '0;
    mem_req    = 1'b0;
    address    = '0;
    store_data = '0;
    mem_op     = OP_LW;
    rst_n      = 1'b0;

    @(negedge clk);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("rst_mread", {31'd0, bus.MemRead}, 32'd0);
    check("rst_load", load_data, 32'd0);
    check("rst_exc", {31'd0, exc}, 32'd0);
    step();
    rst_n = 1'b1;

    preload(3'd1, 32'h000003E3);
    drive(OP_LB, 32'h4, '0);
    @(negedge clk);
    check("lb_data", load_data, 32'hFFFFFFE3);
    check("lb_stall", {31'd0, stall}, 32'd0);
    check("lb_mread", {31'd0, bus.MemRead}, 32'd1);
    check("lb_maddr", bus.MemAddress, 32'h4);
    step();
    drive(OP_LBU, 32'h4, '0);
    @(negedge clk);
    check("lbu_data", load_data, 32'h000000E3);
    step();

    preload(3'd1, 32'h8001ABCD);
    drive(OP_LH, 32'h6, '0);
    @(negedge clk);
    check("lh_data", load_data, 32'hFFFF8001);
    check("lh_maddr", bus.MemAddress, 32'h4);
    step();
    drive(OP_LHU, 32'h4, '0);
    @(negedge clk);
    check("lhu_data", load_data, 32'h0000ABCD);
    step();
    drive(OP_LB, 32'h7, '0);
    @(negedge clk);
    check("lb3_data", load_data, 32'hFFFFFF80);
    step();
    drive(OP_LW, 32'h4, '0);
    @(negedge clk);
    check("lw_data", load_data, 32'h8001ABCD);
    step();
    mem_req = 1'b0;
    @(negedge clk);
    check("noreq_load", load_data, 32'd0);
    check("noreq_mread", {31'd0, bus.MemRead}, 32'd0);
    step();

    preload(3'd2, 32'h11223344);
    drive(OP_SB, 32'h9, 32'h123456AA);
    @(negedge clk);
    check("sb_c0_stall", {31'd0, stall}, 32'd1);
    check("sb_c0_mwrite", {31'd0, bus.MemWrite}, 32'd0);
    check("sb_c0_mread", {31'd0, bus.MemRead}, 32'd1);
    check("sb_c0_maddr", bus.MemAddress, 32'h8);
    step();
    @(negedge clk);
    check("sb_c1_stall", {31'd0, stall}, 32'd0);
    check("sb_c1_mwrite", {31'd0, bus.MemWrite}, 32'd1);
    check("sb_c1_wdata", bus.MemWriteData, 32'h1122AA44);
    check("sb_c1_maddr", bus.MemAddress, 32'h8);
    step();
    check("sb_mem", mem_arr[2], 32'h1122AA44);
    drive(OP_LW, 32'h8, '0);
    @(negedge clk);
    check("after_sb_load", load_data, 32'h1122AA44);
    check("after_sb_stall", {31'd0, stall}, 32'd0);
    step();

    drive(OP_SH, 32'hA, 32'h0000BEEF);
    @(negedge clk);
    check("sh_c0_stall", {31'd0, stall}, 32'd1);
    step();
    @(negedge clk);
    check("sh_c1_wdata", bus.MemWriteData, 32'hBEEFAA44);
    step();
    check("sh_mem", mem_arr[2], 32'hBEEFAA44);

    drive(OP_SW, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    check("sw_mwrite", {31'd0, bus.MemWrite}, 32'd1);
    check("sw_stall", {31'd0, stall}, 32'd0);
    check("sw_wdata", bus.MemWriteData, 32'hDEADBEEF);
    check("sw_maddr", bus.MemAddress, 32'h10);
    step();
    mem_req = 1'b0;
    check("sw_mem", mem_arr[4], 32'hDEADBEEF);

    preload(3'd2, 32'h11223344);
    drive(OP_SH, 32'h8, 32'h00005566);
    @(negedge clk);
    check("rstw_c0_stall", {31'd0, stall}, 32'd1);
    step();
    check("rstw_c1_mwrite", {31'd0, bus.MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_mwrite_drop", {31'd0, bus.MemWrite}, 32'd0);
    mem_req = 1'b0;
    step();
    check("rstw_mem", mem_arr[2], 32'h11223344);
    rst_n = 1'b1;
    @(negedge clk);
    check("rstw_idle_stall", {31'd0, stall}, 32'd0);
    check("rstw_idle_mwrite", {31'd0, bus.MemWrite}, 32'd0);
    step();

    drive(OP_LW, 32'h5, '0);
    @(negedge clk);
`ifdef LSU_MISALIGN_TRAP_EN
    check("mis_exc", {31'd0, exc}, 32'd1);
    check("mis_load", load_data, 32'd0);
    check("mis_mread", {31'd0, bus.MemRead}, 32'd0);
`else
    check("mis_exc", {31'd0, exc}, 32'd0);
    check("mis_load", load_data, 32'h8001ABCD);
    check("mis_maddr", bus.MemAddress, 32'h4);
`endif
    step();
    mem_req = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
